knn_sort_ctrl: RTL and testbench

Sequencer for the KNN classification back end: it collects N (distance, type) pairs streamed from the distance stage, loads them into the packed input arrays of the external `distance_sort` unit, and pulses its `done` start strobe. It then waits for `valid_sort`, runs a K-nearest majority vote over the first K sorted types, and reports one class per classification. The block sits between the distance calculator and the result register file, and owns the sort unit's handshake.

---
 rtl/knn_pkg.sv | 34 +++
 rtl/knn_vote.sv | 76 +++++++
 rtl/knn_sort_ctrl.sv | 163 ++++++++++++++++
 tb/tb_knn_sort_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// ----------------------------------------------------------------------------
// knn_pkg
// Shared definitions for the KNN classification back end: default geometry,
// derived counter/bin widths, and the sequencer state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package knn_pkg;

   // Default geometry; must match the external distance_sort unit.
   localparam int unsigned N_DEF      = 64;
   localparam int unsigned W_DEF      = 32;
   localparam int unsigned TYPE_W_DEF = 3;
   localparam int unsigned K_DEF      = 5;

   // Load counter width and vote bin width for the default build.
   localparam int unsigned CNT_W = $clog2(N_DEF);
   localparam int unsigned BIN_W = $clog2(K_DEF + 1);

   // Sequencer states.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_SORT_REQ  = 3'd2,
      S_SORT_WAIT = 3'd3,
      S_VOTE      = 3'd4,
      S_REPORT    = 3'd5
   } state_e;

   // Bit width able to index v items; never returns less than one bit.
   function automatic int unsigned idx_bits(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/knn_vote.sv
// ----------------------------------------------------------------------------
// knn_vote
// Per-class vote bins for the K-nearest majority vote, plus a combinational
// argmax with lowest-class-code tie-break.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears bins)
//   clr_i         : clear every bin this cycle (takes priority over inc_i)
//   inc_i         : increment the bin selected by type_i
//   type_i        : class code to vote for
//   winner_c_o    : argmax over the bins as they will be after this edge,
//                   so the final vote is included the cycle it is cast
// ----------------------------------------------------------------------------
module knn_vote
   import knn_pkg::*;
#(
   parameter int unsigned TYPE_W = TYPE_W_DEF,
   parameter int unsigned K      = K_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              inc_i,
   input  logic [TYPE_W-1:0] type_i,
   output logic [TYPE_W-1:0] winner_c_o
);

   localparam int unsigned NBINS    = 1 << TYPE_W;
   // K+1 distinct counts fit, so a bin can never wrap during K votes.
   localparam int unsigned BIN_BITS = idx_bits(K + 1);

   logic [BIN_BITS-1:0] bin_q [NBINS];
   logic [BIN_BITS-1:0] bin_d [NBINS];

   // Next bin values: clear, single increment, or hold.
   always_comb begin
      for (int b = 0; b < NBINS; b++) begin
         bin_d[b] = bin_q[b];
      end
      if (clr_i) begin
         for (int b = 0; b < NBINS; b++) begin
            bin_d[b] = '0;
         end
      end else if (inc_i) begin
         bin_d[type_i] = bin_q[type_i] + BIN_BITS'(1);
      end
   end

   // Bin registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NBINS; b++) begin
            bin_q[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NBINS; b++) begin
            bin_q[b] <= bin_d[b];
         end
      end
   end

   // Argmax scanning upward; strict compare keeps the lowest code on a tie.
   always_comb begin
      logic [BIN_BITS-1:0] best_cnt;
      logic [TYPE_W-1:0]   best;
      best_cnt = '0;
      best     = '0;
      for (int b = 0; b < NBINS; b++) begin
         if (bin_d[b] > best_cnt) begin
            best_cnt = bin_d[b];
            best     = TYPE_W'(b);
         end
      end
      winner_c_o = best;
   end

endmodule

// File: rtl/knn_sort_ctrl.sv
// ----------------------------------------------------------------------------
// knn_sort_ctrl
// Sequencer for the KNN back end: collects N (distance, type) samples, loads
// the packed input arrays of the external distance_sort unit, strobes its
// done input, waits for valid_sort, votes over the first K sorted types and
// reports the winning class.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a classification (only honoured in IDLE)
//   in_valid/in_ready     : sample handshake; beat moves on valid & ready
//   in_distance, in_type  : sample payload
//   sort_done             : one-cycle start strobe to the sort unit
//   distance_array        : packed distances, sample i at [(i+1)*W-1 -: W]
//   type_array            : packed types, same slot order
//   valid_sort            : sort result valid (level)
//   type_array_sorted     : sorted types, slot 0 = smallest distance
//   class_out/class_valid : winning class, one-cycle valid pulse
//   busy                  : high in every state except IDLE
// ----------------------------------------------------------------------------
module knn_sort_ctrl
   import knn_pkg::*;
#(
   parameter int unsigned N      = N_DEF,
   parameter int unsigned W      = W_DEF,
   parameter int unsigned TYPE_W = TYPE_W_DEF,
   parameter int unsigned K      = K_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [W-1:0]          in_distance,
   input  logic [TYPE_W-1:0]     in_type,
   output logic                  in_ready,
   output logic                  sort_done,
   output logic [W*N-1:0]        distance_array,
   output logic [TYPE_W*N-1:0]   type_array,
   input  logic                  valid_sort,
   input  logic [TYPE_W*N-1:0]   type_array_sorted,
   output logic [TYPE_W-1:0]     class_out,
   output logic                  class_valid,
   output logic                  busy
);

   localparam int unsigned CNT_BITS = idx_bits(N);
   localparam int unsigned J_BITS   = idx_bits(K);

   state_e                state_q;
   logic [CNT_BITS-1:0]   cnt_q;
   logic [J_BITS-1:0]     j_q;
   logic                  wait_armed_q;
   logic                  in_ready_q;
   logic                  sort_done_q;
   logic [W*N-1:0]        dist_arr_q;
   logic [TYPE_W*N-1:0]   type_arr_q;
   logic [TYPE_W-1:0]     class_out_q;
   logic                  class_valid_q;
   logic                  busy_q;

   logic                  beat_c;
   logic                  vote_clr_c;
   logic                  vote_inc_c;
   logic [TYPE_W-1:0]     vote_type_c;
   logic [TYPE_W-1:0]     winner_c;

   assign beat_c      = (state_q == S_LOAD) && in_valid && in_ready_q;
   // Bins are cleared on the same edge that enters LOAD.
   assign vote_clr_c  = (state_q == S_IDLE) && start;
   assign vote_inc_c  = (state_q == S_VOTE);
   assign vote_type_c = type_array_sorted[32'(j_q)*TYPE_W +: TYPE_W];

   knn_vote #(
      .TYPE_W (TYPE_W),
      .K      (K)
   ) u_vote (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (vote_clr_c),
      .inc_i      (vote_inc_c),
      .type_i     (vote_type_c),
      .winner_c_o (winner_c)
   );

   // Sequencer, load counter and packed sample arrays.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         j_q           <= '0;
         wait_armed_q  <= 1'b0;
         in_ready_q    <= 1'b0;
         sort_done_q   <= 1'b0;
         dist_arr_q    <= '0;
         type_arr_q    <= '0;
         class_out_q   <= '0;
         class_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sort_done_q   <= 1'b0;
         class_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_LOAD;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (beat_c) begin
                  dist_arr_q[32'(cnt_q)*W +: W]           <= in_distance;
                  type_arr_q[32'(cnt_q)*TYPE_W +: TYPE_W] <= in_type;
                  cnt_q <= cnt_q + CNT_BITS'(1);
                  if (cnt_q == CNT_BITS'(N - 1)) begin
                     state_q     <= S_SORT_REQ;
                     in_ready_q  <= 1'b0;
                     sort_done_q <= 1'b1;
                  end
               end
            end
            S_SORT_REQ: begin
               state_q      <= S_SORT_WAIT;
               wait_armed_q <= 1'b0;
            end
            S_SORT_WAIT: begin
               // The first cycle here may still see the previous run's level.
               wait_armed_q <= 1'b1;
               if (wait_armed_q && valid_sort) begin
                  state_q <= S_VOTE;
                  j_q     <= '0;
               end
            end
            S_VOTE: begin
               j_q <= j_q + J_BITS'(1);
               if (j_q == J_BITS'(K - 1)) begin
                  state_q       <= S_REPORT;
                  class_out_q   <= winner_c;
                  class_valid_q <= 1'b1;
               end
            end
            S_REPORT: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready       = in_ready_q;
   assign sort_done      = sort_done_q;
   assign distance_array = dist_arr_q;
   assign type_array     = type_arr_q;
   assign class_out      = class_out_q;
   assign class_valid    = class_valid_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// ----------------------------------------------------------------------------
// tb_knn_sort_ctrl
// Self-checking bench for knn_sort_ctrl (K=5 instance plus a K=1 instance).
// The sort unit is modelled here: it stable-sorts the bench's own sample list
// by distance and presents the sorted types with valid_sort after a delay.
// ----------------------------------------------------------------------------
module tb_knn_sort_ctrl;

   localparam int unsigned N      = 64;
   localparam int unsigned W      = 32;
   localparam int unsigned TYPE_W = 3;
   localparam int unsigned K      = 5;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                start_k1 = 1'b0;
   logic                in_valid = 1'b0;
   logic [W-1:0]        in_distance = '0;
   logic [TYPE_W-1:0]   in_type = '0;
   logic                valid_sort = 1'b0;
   logic [TYPE_W*N-1:0] type_array_sorted = '0;

   logic                in_ready, sort_done, class_valid, busy;
   logic [W*N-1:0]      distance_array;
   logic [TYPE_W*N-1:0] type_array;
   logic [TYPE_W-1:0]   class_out;

   logic                in_ready_k1, sort_done_k1, class_valid_k1, busy_k1;
   logic [W*N-1:0]      distance_array_k1;
   logic [TYPE_W*N-1:0] type_array_k1;
   logic [TYPE_W-1:0]   class_out_k1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accepted = 0;
   int cv_pulses = 0;

   int samp_dist [N];
   int samp_type [N];
   int sorted_types [N];
   bit use_ovr = 1'b0;
   int ovr [5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (!rst && class_valid === 1'b1) cv_pulses <= cv_pulses + 1;

   knn_sort_ctrl #(.N(N), .W(W), .TYPE_W(TYPE_W), .K(K)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_distance(in_distance), .in_type(in_type), .in_ready(in_ready),
      .sort_done(sort_done), .distance_array(distance_array),
      .type_array(type_array), .valid_sort(valid_sort),
      .type_array_sorted(type_array_sorted), .class_out(class_out),
      .class_valid(class_valid), .busy(busy)
   );

   knn_sort_ctrl #(.N(N), .W(W), .TYPE_W(TYPE_W), .K(1)) dut_k1 (
      .clk(clk), .rst(rst), .start(start_k1), .in_valid(in_valid),
      .in_distance(in_distance), .in_type(in_type), .in_ready(in_ready_k1),
      .sort_done(sort_done_k1), .distance_array(distance_array_k1),
      .type_array(type_array_k1), .valid_sort(valid_sort),
      .type_array_sorted(type_array_sorted), .class_out(class_out_k1),
      .class_valid(class_valid_k1), .busy(busy_k1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stable sort of sample indices by distance, then optional override of
   // the first five sorted types.
   task automatic build_sorted();
      int idx [N];
      for (int i = 0; i < N; i++) idx[i] = i;
      for (int i = 1; i < N; i++) begin
         int v = idx[i];
         int p = i - 1;
         while (p >= 0 && samp_dist[idx[p]] > samp_dist[v]) begin
            idx[p+1] = idx[p];
            p--;
         end
         idx[p+1] = v;
      end
      for (int i = 0; i < N; i++) sorted_types[i] = samp_type[idx[i]];
      if (use_ovr) for (int i = 0; i < 5; i++) sorted_types[i] = ovr[i];
   endtask

   // Majority over the first kk sorted types, lowest class on ties.
   function automatic int vote_model(input int kk);
      int cnt [8];
      int best;
      for (int c = 0; c < 8; c++) cnt[c] = 0;
      for (int i = 0; i < kk; i++) cnt[sorted_types[i]]++;
      best = 0;
      for (int c = 1; c < 8; c++) if (cnt[c] > cnt[best]) best = c;
      return best;
   endfunction

   task automatic gen_random();
      use_ovr = 1'b0;
      for (int i = 0; i < N; i++) begin
         samp_dist[i] = int'($urandom_range(0, 255));
         samp_type[i] = int'($urandom_range(0, 7));
      end
   endtask

   // One full classification. lat = cycles from sort_done to valid_sort.
   task automatic do_classify(input int lat, input int maxgap, input bit stale,
                              input bit poke_start, input bit with_k1);
      int t;
      int s;
      int exp_cls;
      int exp_k1;
      logic [TYPE_W*N-1:0] srt;
      build_sorted();
      exp_cls = vote_model(K);
      exp_k1  = sorted_types[0];
      for (int i = 0; i < N; i++) srt[i*TYPE_W +: TYPE_W] = TYPE_W'(sorted_types[i]);

      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL idle_before_start: busy=%b required 0", busy);
      end
      start = 1'b1;
      if (with_k1) start_k1 = 1'b1;
      tick();
      start = 1'b0;
      start_k1 = 1'b0;
      accepted++;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL start_accept: in_ready=%b busy=%b required 1 1", in_ready, busy);
      end

      for (int i = 0; i < N; i++) begin
         if (maxgap > 0) begin
            int g = int'($urandom_range(0, maxgap));
            for (int k = 0; k < g; k++) begin
               in_valid = 1'b0;
               if (poke_start && k == 0) start = 1'b1;
               tick();
               start = 1'b0;
            end
         end
         in_valid    = 1'b1;
         in_distance = W'(samp_dist[i]);
         in_type     = TYPE_W'(samp_type[i]);
         if (i == N - 1) t = cyc;
         tick();
         if (i < N - 1) begin
            checks++;
            if (sort_done !== 1'b0) begin
               errors++; $display("FAIL early_sort_done: beat %0d sort_done=%b required 0", i, sort_done);
            end
         end
      end
      in_valid = 1'b0;

      checks++;
      if (sort_done !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL sort_done_t1: sort_done=%b in_ready=%b required 1 0", sort_done, in_ready);
      end
      if (with_k1) begin
         checks++;
         if (sort_done_k1 !== 1'b1) begin
            errors++; $display("FAIL k1_sort_done: got %b required 1", sort_done_k1);
         end
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (distance_array[i*W +: W] !== W'(samp_dist[i]) ||
             type_array[i*TYPE_W +: TYPE_W] !== TYPE_W'(samp_type[i])) begin
            errors++;
            $display("FAIL slot_%0d: dist=%0d type=%0d required %0d %0d", i,
                     distance_array[i*W +: W], type_array[i*TYPE_W +: TYPE_W],
                     samp_dist[i], samp_type[i]);
         end
      end

      type_array_sorted = srt;
      s = stale ? t + 3 : t + 1 + lat;
      while (cyc < s) begin
         tick();
         checks++;
         if (sort_done !== 1'b0 || class_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sort_wait_cyc%0d: sort_done=%b class_valid=%b busy=%b required 0 0 1",
                     cyc - t, sort_done, class_valid, busy);
         end
      end
      if (!stale) valid_sort = 1'b1;

      for (int k = 1; k <= K; k++) begin
         tick();
         if (k == 1) begin
            if (!stale) valid_sort = 1'b0;
            if (poke_start) start = 1'b1;
         end else begin
            start = 1'b0;
         end
         checks++;
         if (class_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL vote_cyc%0d: class_valid=%b busy=%b required 0 1", k, class_valid, busy);
         end
         if (with_k1) begin
            checks++;
            if (k == 2) begin
               if (class_valid_k1 !== 1'b1 || class_out_k1 !== TYPE_W'(exp_k1)) begin
                  errors++;
                  $display("FAIL k1_report: class_valid=%b class_out=%0d required 1 %0d",
                           class_valid_k1, class_out_k1, exp_k1);
               end
            end else if (class_valid_k1 !== 1'b0) begin
               errors++; $display("FAIL k1_quiet_cyc%0d: class_valid=%b required 0", k, class_valid_k1);
            end
         end
      end
      start = 1'b0;

      tick();
      checks++;
      if (class_valid !== 1'b1 || class_out !== TYPE_W'(exp_cls)) begin
         errors++;
         $display("FAIL report: class_valid=%b class_out=%0d required 1 %0d", class_valid, class_out, exp_cls);
      end
      tick();
      checks++;
      if (class_valid !== 1'b0 || busy !== 1'b0 || class_out !== TYPE_W'(exp_cls)) begin
         errors++;
         $display("FAIL back_to_idle: class_valid=%b busy=%b class_out=%0d required 0 0 %0d",
                  class_valid, busy, class_out, exp_cls);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (in_ready !== 1'b0 || sort_done !== 1'b0 || distance_array !== '0 ||
          type_array !== '0 || class_out !== '0 || class_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: in_ready=%b sort_done=%b class_out=%0d class_valid=%b busy=%b required all 0",
                  in_ready, sort_done, class_out, class_valid, busy);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_load();
      gen_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid    = 1'b1;
         in_distance = W'(samp_dist[i]);
         in_type     = TYPE_W'(samp_type[i]);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || distance_array !== '0 || type_array !== '0) begin
         errors++;
         $display("FAIL reset_mid_load: busy=%b in_ready=%b arrays_zero=%b required 0 0 1",
                  busy, in_ready, (distance_array == '0) && (type_array == '0));
      end
      do_classify(5, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_descending();
      use_ovr = 1'b0;
      for (int i = 0; i < N; i++) begin
         samp_dist[i] = N - 1 - i;
         samp_type[i] = i % 8;
      end
      do_classify(20, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_tie();
      gen_random();
      use_ovr = 1'b1;
      ovr[0] = 3; ovr[1] = 3; ovr[2] = 1; ovr[3] = 1; ovr[4] = 5;
      do_classify(4, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (class_out !== 3'd1) begin
         errors++; $display("FAIL tie_lowest: class_out=%0d required 1", class_out);
      end
      gen_random();
      use_ovr = 1'b1;
      ovr[0] = 2; ovr[1] = 4; ovr[2] = 4; ovr[3] = 2; ovr[4] = 4;
      do_classify(7, 0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (class_out !== 3'd4) begin
         errors++; $display("FAIL majority_4: class_out=%0d required 4", class_out);
      end
      use_ovr = 1'b0;
   endtask

   task automatic test_stale_valid();
      gen_random();
      valid_sort = 1'b1;
      do_classify(0, 0, 1'b1, 1'b0, 1'b0);
      valid_sort = 1'b0;
   endtask

   task automatic test_ignored_start_and_gaps();
      for (int r = 0; r < 2; r++) begin
         gen_random();
         do_classify(int'($urandom_range(2, 12)), 3, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_k1();
      gen_random();
      do_classify(6, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         gen_random();
         do_classify(int'($urandom_range(2, 9)), r, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_load();
      test_descending();
      test_tie();
      test_stale_valid();
      test_ignored_start_and_gaps();
      test_k1();
      test_back_to_back();
      tick();
      checks++;
      if (cv_pulses != accepted) begin
         errors++; $display("FAIL pulse_count: class_valid pulses=%0d required %0d", cv_pulses, accepted);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
